// File: rtl/uart_pin_lock_ctrl.sv
// PIN-entry lock controller: collects ASCII digits from the UART byte stream,
// checks them against a stored code, and drives open/auto-relock/lockout.
module uart_pin_lock_ctrl #(
  parameter int          PIN_LEN        = 4,
  parameter logic [63:0] PIN_CODE       = 64'h31323334,
  parameter int          OPEN_CYCLES    = 250000000,
  parameter int          ENTRY_TIMEOUT  = 500000000,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       lock_open,
  output logic       lockout,
  output logic       bad_pin,
  output logic [2:0] fail_cnt,
  output logic [2:0] state_o
);

  localparam int MAX_OE = (OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT;
  localparam int MAX_T  = (MAX_OE > LOCKOUT_CYCLES) ? MAX_OE : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(MAX_T) + 1;
  localparam int BW     = 8 * PIN_LEN;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_buf;
  logic [3:0]      r_cnt;
  logic            r_ovf;
  logic [TW-1:0]   r_timer;
  logic            r_lock_open;
  logic            r_lockout;
  logic            r_bad_pin;
  logic [2:0]      r_fail_cnt;

  logic            w_digit;
  logic            w_submit;
  logic            w_clear;
  logic            w_extend;
  logic            w_close;
  logic            w_match;
  logic            w_last_fail;
  logic [BW-1:0]   w_shifted;

  // rx_valid is a one-cycle strobe with no backpressure: a byte is consumed
  // in the cycle it is presented or dropped.
  assign w_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign w_submit = (rx_byte == 8'h23);
  assign w_clear  = (rx_byte == 8'h2A);
  assign w_extend = (rx_byte == 8'h41);
  assign w_close  = (rx_byte == 8'h43);

  assign w_shifted   = BW'({r_buf, rx_byte});
  assign w_match     = (r_cnt == 4'(PIN_LEN)) && !r_ovf && (r_buf == PIN_CODE[BW-1:0]);
  assign w_last_fail = (({1'b0, r_fail_cnt} + 4'd1) == 4'(MAX_FAILS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_timer     <= '0;
      r_lock_open <= 1'b0;
      r_lockout   <= 1'b0;
      r_bad_pin   <= 1'b0;
      r_fail_cnt  <= '0;
    end else begin
      r_bad_pin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid && w_digit) begin
            r_buf   <= BW'(rx_byte);
            r_cnt   <= 4'd1;
            r_ovf   <= 1'b0;
            r_timer <= TW'(ENTRY_TIMEOUT);
            r_state <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (rx_valid && (w_digit || w_submit || w_clear)) begin
            r_timer <= TW'(ENTRY_TIMEOUT);
            if (w_digit) begin
              if (r_cnt < 4'(PIN_LEN)) begin
                r_buf <= w_shifted;
                r_cnt <= r_cnt + 4'd1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else if (w_clear) begin
              r_buf   <= '0;
              r_cnt   <= '0;
              r_ovf   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_CHECK;
            end
          end else if (r_timer == '0) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_CHECK: begin
          r_buf <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          if (w_match) begin
            r_fail_cnt  <= '0;
            r_timer     <= TW'(OPEN_CYCLES);
            r_lock_open <= 1'b1;
            r_state     <= S_OPEN;
          end else begin
            r_bad_pin <= 1'b1;
            if (w_last_fail) begin
              r_fail_cnt <= '0;
              r_timer    <= TW'(LOCKOUT_CYCLES);
              r_lockout  <= 1'b1;
              r_state    <= S_LOCKOUT;
            end else begin
              r_fail_cnt <= r_fail_cnt + 3'd1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_OPEN: begin
          // A byte arriving on the expiry cycle takes priority over the timer.
          if (rx_valid && w_close) begin
            r_timer     <= '0;
            r_lock_open <= 1'b0;
            r_state     <= S_IDLE;
          end else if (rx_valid && w_extend) begin
            r_timer <= TW'(OPEN_CYCLES);
          end else if (r_timer <= TW'(1)) begin
            r_timer     <= '0;
            r_lock_open <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (r_timer <= TW'(1)) begin
            r_timer   <= '0;
            r_lockout <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_lock_open <= 1'b0;
          r_lockout   <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign lock_open = r_lock_open;
  assign lockout   = r_lockout;
  assign bad_pin   = r_bad_pin;
  assign fail_cnt  = r_fail_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_uart_pin_lock_ctrl.sv
// Bench for uart_pin_lock_ctrl: directed PIN scenarios plus random byte traffic,
// checked event-by-event against a deadline-based reference model.
module tb_uart_pin_lock_ctrl;

  localparam int OPEN_C  = 100;
  localparam int ENTRY_T = 50;
  localparam int LOCK_C  = 200;
  localparam int MAXF    = 3;
  localparam int PLEN    = 4;
  localparam int W       = 41;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       lock_open;
  logic       lockout;
  logic       bad_pin;
  logic [2:0] fail_cnt;
  logic [2:0] state_o;

  uart_pin_lock_ctrl #(
    .PIN_LEN(PLEN), .PIN_CODE(64'h31323334), .OPEN_CYCLES(OPEN_C),
    .ENTRY_TIMEOUT(ENTRY_T), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .lock_open(lock_open), .lockout(lockout), .bad_pin(bad_pin),
    .fail_cnt(fail_cnt), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: each entry is {edge number, output vector}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: digit queue plus absolute deadlines
  int          m_mode  = 0;
  logic [7:0]  m_dig[$];
  bit          m_ovf   = 0;
  int          m_last  = 0;
  int          m_until = 0;
  int          m_fails = 0;
  bit          m_bad   = 0;
  logic [8:0]  m_prev  = '0;
  string       pin     = "1234";

  function automatic bit is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  task automatic model_step();
    logic [8:0] v;
    bit match;
    cyc++;
    m_bad = 0;
    if (rst) begin
      m_mode = 0; m_dig.delete(); m_ovf = 0; m_fails = 0;
    end else begin
      case (m_mode)
        0: if (rx_valid && is_digit(rx_byte)) begin
             m_dig.delete(); m_dig.push_back(rx_byte); m_ovf = 0; m_last = cyc; m_mode = 1;
           end
        1: if (rx_valid && (is_digit(rx_byte) || rx_byte == 8'h23 || rx_byte == 8'h2A)) begin
             m_last = cyc;
             if (is_digit(rx_byte)) begin
               if (m_dig.size() < PLEN) m_dig.push_back(rx_byte);
               else m_ovf = 1;
             end else if (rx_byte == 8'h2A) begin
               m_dig.delete(); m_ovf = 0; m_mode = 0;
             end else begin
               m_mode = 2;
             end
           end else if (cyc - m_last > ENTRY_T) begin
             m_dig.delete(); m_ovf = 0; m_mode = 0;
           end
        2: begin
             match = (m_dig.size() == PLEN) && !m_ovf;
             for (int i = 0; i < PLEN; i++)
               if (match && m_dig[i] != pin[i]) match = 0;
             if (match) begin
               m_fails = 0; m_until = cyc + OPEN_C; m_mode = 3;
             end else begin
               m_bad = 1;
               if (m_fails + 1 == MAXF) begin
                 m_fails = 0; m_until = cyc + LOCK_C; m_mode = 4;
               end else begin
                 m_fails++; m_mode = 0;
               end
             end
             m_dig.delete(); m_ovf = 0;
           end
        3: if (rx_valid && rx_byte == 8'h43) m_mode = 0;
           else if (rx_valid && rx_byte == 8'h41) m_until = cyc + OPEN_C;
           else if (cyc >= m_until) m_mode = 0;
        default: if (cyc >= m_until) m_mode = 0;
      endcase
    end
    v = {m_mode == 3, m_mode == 4, m_bad, 3'(m_fails), 3'(m_mode)};
    if (cyc == 1 || v != m_prev) exp_q.push_back({32'(cyc), v});
    m_prev = v;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // monitor: every change of the DUT outputs is one scoreboard comparison
  task automatic check_evt(input logic [8:0] v);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e == {32'(cyc), v}) n_pass++;
      else $display("FAIL out_event got cyc=%0d vec=%b required cyc=%0d vec=%b (lock,lockout,bad,fail[3],state[3])",
                    cyc, v, e[W-1:9], e[8:0]);
    end
  endtask

  initial begin
    logic [8:0] last;
    logic [8:0] v;
    bit started;
    started = 0;
    last = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        v = {lock_open, lockout, bad_pin, fail_cnt, state_o};
        if (!started || v != last) begin
          started = 1;
          last = v;
          check_evt(v);
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_misc(input int k);
    case (k)
      0: return 8'h2A;
      1: return 8'h41;
      2: return 8'h43;
      3: return 8'h23;
      4: return 8'h78;
      5: return 8'h00;
      6: return 8'h35;
      default: return 8'h33;
    endcase
  endfunction

  initial begin
    int kind;
    int n;
    int g;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
    // correct PIN, auto-relock
    send_str("1234#", 0); idle(120);
    // extend at open-cycle 60, then close early
    send_str("1234#", 0); idle(60); send_byte("A", 0); idle(120);
    send_str("1234#", 0); idle(20); send_byte("C", 0); idle(5);
    // three failures -> lockout, PIN ignored while locked out
    send_str("1235#", 1); idle(3); send_str("12#", 0); idle(3);
    send_str("12345#", 0); idle(10); send_str("1234#", 0); idle(220);
    send_str("1234#", 0); idle(110);
    // entry timeout, then clear
    send_str("12", 0); idle(60); send_str("34#", 0); idle(5);
    send_str("12*1234#", 0); idle(110);
    // reset in OPEN and in LOCKOUT
    send_str("1234#", 0); idle(30); pulse_rst(); idle(5);
    send_str("9#", 0); send_str("9#", 0); send_str("9#", 0); idle(20); pulse_rst(); idle(5);
    // non-class bytes interleaved
    send_byte("x", 0); send_byte("#", 0);
    send_str("1", 0); send_byte(8'h00, 0); send_str("x2y", 0); send_byte(8'h00, 0);
    send_str("3z4", 0); send_byte(8'h00, 0); send_str("#", 0); idle(110);
    // random traffic
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      g = $urandom_range(0, 3);
      if (kind < 3) begin
        send_str("1234#", g);
      end else if (kind < 6) begin
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) send_byte(8'(8'h30 + $urandom_range(0, 9)), g);
        send_byte("#", g);
      end else if (kind < 8) begin
        send_byte(pick_misc($urandom_range(0, 7)), g);
      end else if (kind == 8) begin
        idle($urandom_range(0, 120));
      end else if ($urandom_range(0, 3) == 0) begin
        pulse_rst();
      end else begin
        idle(10);
      end
    end
    idle(260);
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event got no change required cyc=%0d vec=%b", e[W-1:9], e[8:0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_pin_lock_ctrl.md
Name: uart_pin_lock_ctrl

Overview:
PIN-entry controller for the UART-driven door lock. Consumes the byte stream from the uart_rx instance (rx_valid/rx_byte). Collects an ASCII numeric PIN, compares it with a stored code, and drives the lock. Applies auto-relock after a timeout and a lockout after repeated failures. Replaces the direct 'A'/'C' open/close decode in the lock top level.

Parameters:
PIN_LEN, 4, number of digits in the PIN (1..8)
PIN_CODE, 32'h31323334, expected PIN as ASCII digits, first digit in the most significant used byte ("1234")
OPEN_CYCLES, 250000000, cycles the lock stays open (5 s at 50 MHz)
ENTRY_TIMEOUT, 500000000, idle cycles allowed between bytes in ENTRY before entry is discarded
MAX_FAILS, 3, consecutive wrong PINs that trigger lockout (1..7)
LOCKOUT_CYCLES, 1500000000, lockout duration in cycles

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
rx_valid  input  1  one-cycle strobe; rx_byte is valid in this cycle
rx_byte  input  8  received ASCII byte
lock_open  output  1  1 = lock released
lockout  output  1  1 = lockout active; all input ignored
bad_pin  output  1  one-cycle pulse on every rejected PIN
fail_cnt  output  3  current consecutive-failure count
state_o  output  3  FSM state: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; lock_open=0, lockout=0, bad_pin=0, fail_cnt=0; digit buffer, digit count, overflow flag and timer all cleared. Reset takes effect mid-operation from any state, including OPEN, which closes the lock at once.
- Byte classes: digit is 0x30..0x39; '#' (0x23) is submit; '*' (0x2A) is clear; 'A' (0x41) is extend; 'C' (0x43) is close. All other bytes are ignored in every state.
- All outputs are registered. lock_open=1 exactly while state=OPEN. lockout=1 exactly while state=LOCKOUT.
- IDLE:
  - digit: buffer={digit}, cnt=1, timer=ENTRY_TIMEOUT, go to ENTRY.
  - '#' with no digits entered: ignored (no failure counted).
- ENTRY:
  - Every accepted byte reloads timer=ENTRY_TIMEOUT.
  - digit with cnt<PIN_LEN: shift the digit into the buffer (left shift by 8), cnt++.
  - digit with cnt==PIN_LEN: set overflow; the digit is discarded.
  - '*': clear the buffer, cnt and overflow; go to IDLE; no failure counted.
  - '#': go to CHECK.
  - Timer reaching 0 with no rx_valid: clear and go to IDLE; no failure counted.
- CHECK (exactly 1 cycle; rx_valid in this cycle is dropped):
  - Match = (cnt==PIN_LEN) and !overflow and buffer==PIN_CODE[8*PIN_LEN-1:0].
  - Match: fail_cnt=0, timer=OPEN_CYCLES, go to OPEN.
  - Mismatch: bad_pin pulses for 1 cycle.
    - If fail_cnt+1==MAX_FAILS: fail_cnt=0, timer=LOCKOUT_CYCLES, go to LOCKOUT.
    - Otherwise: fail_cnt++ and go to IDLE.
  - The buffer is cleared on exit in all cases.
- OPEN:
  - Timer decrements each cycle; lock_open stays high for exactly OPEN_CYCLES cycles, then state=IDLE.
  - 'C': go to IDLE on the next edge.
  - 'A': timer=OPEN_CYCLES.
  - Digits, '#' and '*' are ignored.
  - If 'C' or 'A' arrives in the same cycle the timer expires, the byte wins.
- LOCKOUT: all bytes ignored; timer decrements; after exactly LOCKOUT_CYCLES cycles, state=IDLE.
- Latency: '#' sampled at edge N puts state in CHECK after N and in OPEN after N+1. lock_open therefore rises on the second edge after the '#' strobe. bad_pin is asserted in the cycle following CHECK.
- Timer width: $clog2 of the largest of OPEN_CYCLES, ENTRY_TIMEOUT, LOCKOUT_CYCLES, plus 1. The timer is an unsigned down-counter that saturates at 0.
- Failure history: fail_cnt persists across IDLE/ENTRY. Only a successful PIN, a lockout or rst clears it.

Test Plan:
(All sims use OPEN_CYCLES=100, ENTRY_TIMEOUT=50, LOCKOUT_CYCLES=200, MAX_FAILS=3.)
1. Send "1234#" -> lock_open=1 two edges after the '#' strobe, held for exactly 100 cycles, then 0; fail_cnt=0 throughout.
2. Send "1234#", then 'A' at open-cycle 60 -> lock_open stays high 100 cycles after the 'A'. Next, send "1234#" then 'C' -> lock_open=0 one edge after the 'C' strobe.
3. Send "1235#", "12#", then "12345#" -> bad_pin pulses three times; fail_cnt steps 1, 2, then state=LOCKOUT, lockout=1, fail_cnt=0. Send "1234#" during lockout -> lock_open stays 0. After 200 cycles state=IDLE, and a subsequent "1234#" opens the lock.
4. Send "12", wait 60 idle cycles, send "34#" -> entry times out to IDLE; "34#" is rejected with bad_pin and fail_cnt=1. Send "12*1234#" -> lock opens with no failure counted by the '*'.
5. Assert rst for 1 cycle while in OPEN at cycle 30, and separately while in LOCKOUT -> lock_open=0 and lockout=0 on the next edge, state_o=0, fail_cnt=0.
6. Send 'x', '#' in IDLE, and 0x00 interleaved within "1x2y3z4#" -> non-class bytes ignored; lock opens normally.
